ide_xfer_engine: RTL and testbench
==================================

Name: ide_xfer_engine

Overview:
- Parametrised data-phase engine for the IDE device side.
- Moves words between the host data register and a word buffer in either direction.
- Supports PIO and multiword DMA. DMA uses a DMARQ/DMACK handshake with programmable burst length and inter-burst pause.
- Sits between the synchronised IDE pins and the data buffer. The AVR-facing register block drives it with start/abort/count and observes busy/done/pos.

Parameters:
ADDR_W, 8, buffer word-address width; depth = 2**ADDR_W words
DATA_W, 16, bus/buffer word width
BURST, 16, words per DMA burst before DMARQ drops; 0 = no bursts (single request for whole transfer)
PAUSE_CYC, 4, clk cycles DMARQ stays low between bursts (minimum 1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
dior_n  in  1  synchronised host read strobe, active low
diow_n  in  1  synchronised host write strobe, active low
dmack_n  in  1  synchronised DMA acknowledge, active low
data_sel  in  1  current PIO access targets the data register with this drive selected
dd_in  in  DATA_W  latched host write data
dd_out  out  DATA_W  host read data
dmarq  out  1  DMA request to pin driver
start  in  1  one-cycle pulse: begin transfer
dir  in  1  sampled at start: 1 = host writes into buffer, 0 = host reads from buffer
dma_mode  in  1  sampled at start: 1 = multiword DMA, 0 = PIO
count  in  ADDR_W+1  sampled at start: words to transfer, 0..2**ADDR_W
abort  in  1  one-cycle pulse: cancel transfer
buf_addr  out  ADDR_W  buffer word address
buf_wdata  out  DATA_W  buffer write data
buf_we  out  1  buffer write enable
buf_rdata  in  DATA_W  buffer read data, valid 1 cycle after buf_addr
busy  out  1  transfer in progress
done  out  1  one-cycle pulse on normal completion
pos  out  ADDR_W+1  words completed in current/last transfer

Behaviour:
- Reset values: dd_out=0, dmarq=0, buf_addr=0, buf_wdata=0, buf_we=0, busy=0, done=0, pos=0; state IDLE.
- Strobes are registered one extra stage.
  - A word completes on the rising edge (0->1) of the strobe matching dir: diow_n if dir=1, dior_n if dir=0.
  - A word starts on the falling edge of that strobe.
  - The non-matching strobe is always ignored.
- Qualification of the active strobe:
  - PIO: data_sel=1 at the edge.
  - DMA: dmack_n=0 at the edge.
  - Unqualified edges are ignored.
- buf_addr = pos[ADDR_W-1:0] at all times.
  - Read direction: dd_out <= buf_rdata every cycle, so dd_out is valid 2 cycles after pos changes.
  - Write direction: on a completing edge, buf_we=1 for exactly one cycle with buf_wdata=dd_in and buf_addr=old pos. pos increments in the same cycle.
- States:
  - IDLE: busy=0. On start: latch dir/mode/count, pos<=0, busy<=1.
    - count=0 -> DONE.
    - Else PIO, or DMA_REQ if dma_mode=1.
  - PIO: on each completing edge pos++. When pos reaches count -> DONE.
  - DMA_REQ: dmarq=1, burst counter bcnt counts words in the current burst.
    - On a qualified falling edge where this word is the last of the burst (bcnt==BURST-1, BURST!=0) or the last of the transfer (pos==count-1): dmarq<=0 next cycle.
    - On completing edge: pos++, bcnt++.
    - Last of transfer -> DONE. Last of burst -> DMA_PAUSE with bcnt<=0.
  - DMA_PAUSE: dmarq=0. Wait PAUSE_CYC cycles AND dmack_n=1, then -> DMA_REQ.
  - DONE: done=1 for one cycle, busy<=0, -> IDLE. pos holds its final value.
- abort in any non-IDLE state: next cycle state=IDLE, dmarq=0, busy=0, buf_we=0, no done pulse, pos holds.
- abort in IDLE has no effect.
- start while busy is ignored. start and abort in the same cycle: abort wins.
- count = 2**ADDR_W transfers the full buffer. buf_addr wraps to 0 after the last word but is not used further.
- Host edges in IDLE, DONE or DMA_PAUSE cause no buffer write and no pos change.
- rst mid-transfer returns everything to reset values immediately.

Test Plan:
- PIO host write: dir=1, dma_mode=0, count=3, three diow_n pulses with data_sel=1 and dd_in=0x1111/0x2222/0x3333 -> buf_we pulses at addr 0,1,2 with those words; pos=3; done pulses once; busy=0.
- PIO read with qualification: dir=0, count=2, buffer {0xAAAA,0x5555}; one dior_n pulse with data_sel=0, then two with data_sel=1 -> unqualified pulse ignored; dd_out shows 0xAAAA then 0x5555; pos=2.
- DMA bursts: BURST=4, PAUSE_CYC=4, dir=1, count=10 -> dmarq high, drops on the falling strobe of words 4 and 8, low >=4 cycles and until dmack_n=1 between bursts; dmarq drops on word 10; done after the 10th rising edge.
- count=0 start -> done pulses 2 cycles after start; no buf_we; dmarq never asserts.
- abort during DMA after 5 of 10 words -> dmarq=0 and busy=0 next cycle; pos=5; no done; later strobes ignored.
- Full depth plus reset: ADDR_W=4, count=16 PIO write -> addresses 0..15 written, pos=16. Repeat and assert rst at word 7 -> all outputs return to reset values.

Source files
------------

// File: rtl/ide_xfer_engine.sv
// IDE device-side data-phase engine: moves words between the host data register and a
// word buffer using PIO strobes or multiword DMA bursts with a DMARQ/DMACK handshake.
module ide_xfer_engine #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int BURST     = 16,
    parameter int PAUSE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dior_n,
    input  logic              diow_n,
    input  logic              dmack_n,
    input  logic              data_sel,
    input  logic [DATA_W-1:0] dd_in,
    output logic [DATA_W-1:0] dd_out,
    output logic              dmarq,
    input  logic              start,
    input  logic              dir,
    input  logic              dma_mode,
    input  logic [ADDR_W:0]   count,
    input  logic              abort,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [DATA_W-1:0] buf_wdata,
    output logic              buf_we,
    input  logic [DATA_W-1:0] buf_rdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   pos
);
    localparam int PCW = (PAUSE_CYC < 2) ? 1 : $clog2(PAUSE_CYC);
    localparam logic [PCW-1:0] PMAX = PCW'(PAUSE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PIO,
        S_DMA_REQ,
        S_DMA_PAUSE,
        S_DONE
    } state_t;

    state_t              state_q;
    logic                dir_q, dma_q, busy_q, done_q, dmarq_q;
    logic [ADDR_W:0]     cnt_q, pos_q, bcnt_q;
    logic [PCW-1:0]      pcnt_q;
    logic [DATA_W-1:0]   dd_out_q, dd_q;
    logic                rd_q, rd_qq, wr_q, wr_qq, sel_q, ack_q;

    logic                stb_q, stb_qq, qual, rise, fall, active, cmpl;
    logic                last_burst, last_xfer;
    logic [ADDR_W:0]     pos_d;

    // Edges are seen between the two strobe stages; qualifiers and data share the first stage.
    assign stb_q      = dir_q ? wr_q  : rd_q;
    assign stb_qq     = dir_q ? wr_qq : rd_qq;
    assign qual       = dma_q ? ~ack_q : sel_q;
    assign rise       = stb_q & ~stb_qq & qual;
    assign fall       = ~stb_q & stb_qq & qual;
    assign active     = (state_q == S_PIO) || (state_q == S_DMA_REQ);
    assign cmpl       = active & rise;
    assign pos_d      = pos_q + {{ADDR_W{1'b0}}, 1'b1};
    assign last_burst = (BURST != 0) && (32'(bcnt_q) == 32'(BURST - 1));
    assign last_xfer  = (pos_q == cnt_q - {{ADDR_W{1'b0}}, 1'b1});

    assign buf_addr  = pos_q[ADDR_W-1:0];
    assign buf_wdata = dd_q;
    assign buf_we    = cmpl & dir_q & ~abort;
    assign dd_out    = dd_out_q;
    assign dmarq     = dmarq_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pos       = pos_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            dir_q    <= 1'b0;
            dma_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dmarq_q  <= 1'b0;
            cnt_q    <= '0;
            pos_q    <= '0;
            bcnt_q   <= '0;
            pcnt_q   <= '0;
            dd_out_q <= '0;
            dd_q     <= '0;
            rd_q     <= 1'b1;
            rd_qq    <= 1'b1;
            wr_q     <= 1'b1;
            wr_qq    <= 1'b1;
            sel_q    <= 1'b0;
            ack_q    <= 1'b1;
        end else begin
            rd_q     <= dior_n;
            rd_qq    <= rd_q;
            wr_q     <= diow_n;
            wr_qq    <= wr_q;
            sel_q    <= data_sel;
            ack_q    <= dmack_n;
            dd_q     <= dd_in;
            dd_out_q <= buf_rdata;
            done_q   <= 1'b0;

            if (abort && state_q != S_IDLE) begin
                state_q <= S_IDLE;
                dmarq_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start && !abort) begin
                            dir_q  <= dir;
                            dma_q  <= dma_mode;
                            cnt_q  <= count;
                            pos_q  <= '0;
                            bcnt_q <= '0;
                            busy_q <= 1'b1;
                            if (count == '0) begin
                                state_q <= S_DONE;
                            end else if (dma_mode) begin
                                state_q <= S_DMA_REQ;
                                dmarq_q <= 1'b1;
                            end else begin
                                state_q <= S_PIO;
                            end
                        end
                    end
                    S_PIO: begin
                        if (cmpl) begin
                            pos_q <= pos_d;
                            if (pos_d == cnt_q) state_q <= S_DONE;
                        end
                    end
                    S_DMA_REQ: begin
                        // Drop the request as the final word of a burst starts, not when it ends.
                        if (fall && (last_burst || last_xfer)) dmarq_q <= 1'b0;
                        if (cmpl) begin
                            pos_q  <= pos_d;
                            bcnt_q <= bcnt_q + {{ADDR_W{1'b0}}, 1'b1};
                            if (pos_d == cnt_q) begin
                                state_q <= S_DONE;
                                dmarq_q <= 1'b0;
                            end else if (last_burst) begin
                                state_q <= S_DMA_PAUSE;
                                bcnt_q  <= '0;
                                pcnt_q  <= '0;
                                dmarq_q <= 1'b0;
                            end
                        end
                    end
                    S_DMA_PAUSE: begin
                        if (pcnt_q == PMAX) begin
                            if (ack_q) begin
                                state_q <= S_DMA_REQ;
                                dmarq_q <= 1'b1;
                            end
                        end else begin
                            pcnt_q <= pcnt_q + {{(PCW-1){1'b0}}, 1'b1};
                        end
                    end
                    S_DONE: begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ide_xfer_engine.sv
// Directed bench for ide_xfer_engine: PIO vector table plus DMA burst, abort and reset sequences.
module tb_ide_xfer_engine;
    logic        clk = 1'b0;
    logic        rst, dior_n, diow_n, dmack_n, data_sel;
    logic [15:0] dd_in, dd_out, buf_wdata, buf_rdata;
    logic        dmarq, start, dir, dma_mode, abort, buf_we, busy, done;
    logic [4:0]  count, pos;
    logic [3:0]  buf_addr;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;
    int done_cnt = 0;
    logic [15:0] mem  [16];
    logic [15:0] wmem [16];

    ide_xfer_engine #(.ADDR_W(4), .DATA_W(16), .BURST(4), .PAUSE_CYC(4)) dut (
        .clk(clk), .rst(rst), .dior_n(dior_n), .diow_n(diow_n), .dmack_n(dmack_n),
        .data_sel(data_sel), .dd_in(dd_in), .dd_out(dd_out), .dmarq(dmarq),
        .start(start), .dir(dir), .dma_mode(dma_mode), .count(count), .abort(abort),
        .buf_addr(buf_addr), .buf_wdata(buf_wdata), .buf_we(buf_we),
        .buf_rdata(buf_rdata), .busy(busy), .done(done), .pos(pos)
    );

    always #5 clk = ~clk;

    always @(posedge clk) buf_rdata <= mem[buf_addr];

    always @(negedge clk) begin
        if (buf_we === 1'b1) begin
            wmem[buf_addr] = buf_wdata;
            wr_cnt++;
        end
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (got running, expected finished)");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic do_start(input logic d, input logic m, input logic [4:0] c);
        dir = d; dma_mode = m; count = c; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse(input logic use_wr, input logic sel, input logic [15:0] d);
        data_sel = sel; dd_in = d;
        if (use_wr) diow_n = 1'b0; else dior_n = 1'b0;
        ticks(3);
        diow_n = 1'b1; dior_n = 1'b1;
        ticks(5);
    endtask

    task automatic wait_req(input string nm);
        int i;
        i = 0;
        while (dmarq !== 1'b1 && i < 30) begin
            tick();
            i++;
        end
        check(nm, dmarq, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dd_out"}, dd_out, 0);
        check({tag, "_dmarq"}, dmarq, 0);
        check({tag, "_buf_addr"}, buf_addr, 0);
        check({tag, "_buf_wdata"}, buf_wdata, 0);
        check({tag, "_buf_we"}, buf_we, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pos"}, pos, 0);
    endtask

    typedef struct {
        logic       dir;
        logic       wrong;
        logic [4:0] cnt;
        int         npulse;
        logic [3:0] qmask;
        logic [4:0] exp_pos;
        int         exp_wr;
        int         exp_done;
        logic       exp_busy;
    } vec_t;

    initial begin
        vec_t        tv[7];
        logic [15:0] exp_words[$];
        logic [15:0] dat;
        int          w0, d0, n;
        logic        lastb, seen_hi;

        tv[0] = '{1'b1, 1'b0, 5'd3, 3, 4'b0111, 5'd3, 3, 1, 1'b0};
        tv[1] = '{1'b1, 1'b0, 5'd2, 3, 4'b0101, 5'd2, 2, 1, 1'b0};
        tv[2] = '{1'b0, 1'b0, 5'd2, 3, 4'b0110, 5'd2, 0, 1, 1'b0};
        tv[3] = '{1'b1, 1'b0, 5'd4, 2, 4'b0011, 5'd2, 2, 0, 1'b1};
        tv[4] = '{1'b1, 1'b1, 5'd1, 2, 4'b0011, 5'd0, 0, 0, 1'b1};
        tv[5] = '{1'b0, 1'b0, 5'd1, 1, 4'b0001, 5'd1, 0, 1, 1'b0};
        tv[6] = '{1'b1, 1'b0, 5'd2, 4, 4'b1111, 5'd2, 2, 1, 1'b0};

        for (int i = 0; i < 16; i++) mem[i] = 16'h0100 + 16'(i);
        mem[0] = 16'hAAAA;
        mem[1] = 16'h5555;

        rst = 1'b1; dior_n = 1'b1; diow_n = 1'b1; dmack_n = 1'b1; data_sel = 1'b0;
        dd_in = '0; start = 1'b0; abort = 1'b0; dir = 1'b0; dma_mode = 1'b0; count = '0;
        ticks(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // PIO vector table
        for (int v = 0; v < 7; v++) begin
            w0 = wr_cnt; d0 = done_cnt;
            exp_words.delete();
            do_start(tv[v].dir, 1'b0, tv[v].cnt);
            for (int p = 0; p < tv[v].npulse; p++) begin
                dat = 16'hA000 + 16'(v * 16 + p);
                pulse(tv[v].dir ^ tv[v].wrong, tv[v].qmask[p], dat);
                if (tv[v].qmask[p] && !tv[v].wrong && exp_words.size() < int'(tv[v].cnt))
                    exp_words.push_back(dat);
            end
            ticks(2);
            check($sformatf("vec%0d_pos", v), pos, tv[v].exp_pos);
            check($sformatf("vec%0d_writes", v), wr_cnt - w0, tv[v].exp_wr);
            check($sformatf("vec%0d_done", v), done_cnt - d0, tv[v].exp_done);
            check($sformatf("vec%0d_busy", v), busy, tv[v].exp_busy);
            if (tv[v].dir && !tv[v].wrong)
                for (int j = 0; j < tv[v].exp_wr; j++)
                    check($sformatf("vec%0d_wdata%0d", v, j), wmem[j], exp_words[j]);
            if (tv[v].exp_busy) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                check($sformatf("vec%0d_abort_busy", v), busy, 0);
                check($sformatf("vec%0d_abort_pos", v), pos, tv[v].exp_pos);
            end
        end

        // PIO read: data follows pos through the buffer pipeline
        d0 = done_cnt;
        do_start(1'b0, 1'b0, 5'd2);
        ticks(3);
        check("rd_first_word", dd_out, 16'hAAAA);
        pulse(1'b0, 1'b0, 16'h0);
        check("rd_unqual_pos", pos, 0);
        pulse(1'b0, 1'b1, 16'h0);
        check("rd_pos1", pos, 1);
        check("rd_second_word", dd_out, 16'h5555);
        pulse(1'b0, 1'b1, 16'h0);
        check("rd_pos2", pos, 2);
        check("rd_done", done_cnt - d0, 1);

        // start while busy is ignored
        d0 = done_cnt;
        do_start(1'b1, 1'b0, 5'd4);
        pulse(1'b1, 1'b1, 16'hB000);
        do_start(1'b0, 1'b0, 5'd1);
        for (int i = 1; i < 4; i++) pulse(1'b1, 1'b1, 16'hB000 + 16'(i));
        check("restart_pos", pos, 4);
        check("restart_done", done_cnt - d0, 1);
        check("restart_wdata1", wmem[1], 16'hB001);

        // start and abort together in IDLE
        d0 = done_cnt;
        dir = 1'b1; dma_mode = 1'b0; count = 5'd2; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", busy, 0);
        ticks(2);
        check("start_abort_done", done_cnt - d0, 0);

        // zero-length transfer
        w0 = wr_cnt; d0 = done_cnt;
        dir = 1'b1; dma_mode = 1'b1; count = 5'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("zero_done_early", done, 0);
        check("zero_busy", busy, 1);
        tick();
        check("zero_done", done, 1);
        check("zero_dmarq", dmarq, 0);
        tick();
        check("zero_done_once", done, 0);
        check("zero_busy_end", busy, 0);
        check("zero_writes", wr_cnt - w0, 0);

        // DMA write, 10 words in bursts of 4
        w0 = wr_cnt; d0 = done_cnt;
        do_start(1'b1, 1'b1, 5'd10);
        wait_req("dma_req_first");
        for (int w = 1; w <= 10; w++) begin
            dmack_n = 1'b0;
            dd_in = 16'hD000 + 16'(w);
            diow_n = 1'b0;
            ticks(3);
            lastb = (w % 4 == 0) || (w == 10);
            check($sformatf("dma_w%0d_dmarq", w), dmarq, lastb ? 0 : 1);
            diow_n = 1'b1;
            tick();
            if (w == 8) begin
                dmack_n = 1'b1;
                n = 0;
                while (dmarq !== 1'b1 && n < 20) begin
                    tick();
                    n++;
                end
                check("dma_pause2_len", (n >= 4 && n <= 5), 1);
            end else begin
                ticks(4);
            end
            if (w == 4) begin
                seen_hi = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    tick();
                    seen_hi = seen_hi | dmarq;
                end
                check("dma_pause1_hold", seen_hi, 0);
                dmack_n = 1'b1;
                wait_req("dma_req_burst2");
            end
        end
        dmack_n = 1'b1;
        ticks(2);
        check("dma_pos", pos, 10);
        check("dma_writes", wr_cnt - w0, 10);
        check("dma_done", done_cnt - d0, 1);
        check("dma_busy", busy, 0);
        check("dma_dmarq_end", dmarq, 0);
        for (int j = 0; j < 10; j++)
            check($sformatf("dma_wdata%0d", j), wmem[j], 16'hD001 + 16'(j));

        // DMA abort after 5 of 10 words
        w0 = wr_cnt; d0 = done_cnt;
        do_start(1'b1, 1'b1, 5'd10);
        wait_req("abt_req_first");
        for (int w = 1; w <= 5; w++) begin
            dmack_n = 1'b0;
            dd_in = 16'hE000 + 16'(w);
            diow_n = 1'b0;
            ticks(3);
            diow_n = 1'b1;
            ticks(5);
            if (w == 4) begin
                dmack_n = 1'b1;
                wait_req("abt_req_burst2");
            end
        end
        check("abt_pre_busy", busy, 1);
        check("abt_pre_pos", pos, 5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abt_dmarq", dmarq, 0);
        check("abt_busy", busy, 0);
        check("abt_pos", pos, 5);
        dmack_n = 1'b0;
        pulse(1'b1, 1'b0, 16'hE0FF);
        dmack_n = 1'b1;
        check("abt_late_pos", pos, 5);
        check("abt_writes", wr_cnt - w0, 5);
        check("abt_no_done", done_cnt - d0, 0);

        // full-depth PIO write
        w0 = wr_cnt; d0 = done_cnt;
        do_start(1'b1, 1'b0, 5'd16);
        for (int i = 0; i < 16; i++) pulse(1'b1, 1'b1, 16'hC000 + 16'(i));
        ticks(2);
        check("full_pos", pos, 16);
        check("full_buf_addr_wrap", buf_addr, 0);
        check("full_writes", wr_cnt - w0, 16);
        check("full_done", done_cnt - d0, 1);
        check("full_busy", busy, 0);
        for (int j = 0; j < 16; j++)
            check($sformatf("full_wdata%0d", j), wmem[j], 16'hC000 + 16'(j));

        // reset in the middle of word 7
        w0 = wr_cnt;
        do_start(1'b1, 1'b0, 5'd16);
        for (int i = 0; i < 6; i++) pulse(1'b1, 1'b1, 16'hF000 + 16'(i));
        check("rst_pre_pos", pos, 6);
        dd_in = 16'hF006;
        diow_n = 1'b0;
        ticks(2);
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst = 1'b0;
        diow_n = 1'b1;
        ticks(5);
        check("rst_post_pos", pos, 0);
        check("rst_post_busy", busy, 0);
        check("rst_writes", wr_cnt - w0, 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
